hilo_muldiv: RTL and testbench

- Parametrised successor to the plain HI/LO register pair.
- Holds the architectural HI and LO registers and supports independent MTHI/MTLO writes.
- Adds an iterative signed/unsigned multiply and divide engine whose result lands in HI/LO after a fixed latency.
- Sits in the EX stage: the pipeline issues MULT/MULTU/DIV/DIVU through `start`, stalls on `busy`, and reads `rd_hi`/`rd_lo` for MFHI/MFLO.

---
 rtl/hilo_muldiv_pkg.sv | 17 +
 rtl/hilo_muldiv_iter.sv | 78 +++++++
 rtl/hilo_muldiv.sv | 146 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_pkg: shared definitions for the HI/LO register block and its
// iterative multiply/divide engine.
//   - op encoding constants (OP_MULT .. OP_DIVU)
//   - control FSM state enum
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hilo_muldiv_iter.sv
// muldiv_iter: radix-2 iterative unsigned multiply / restoring divide core.
// Works purely on magnitudes; sign handling lives in the parent.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture operands and arm the counter (WIDTH-1)
//   step            perform one iteration this cycle
//   is_div          operation class, sampled on load
//   opd_a, opd_b    unsigned multiplicand/dividend, multiplier/divisor
//   last            counter has reached zero (final iteration)
//   res_hi, res_lo  result of the current iteration (next-state values):
//                   product {hi,lo}, or remainder (hi) / quotient (lo)
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opd_a,
    input  logic [WIDTH-1:0] opd_b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc: upper product half / partial remainder
    // q:   multiplier being shifted out / dividend shifted out, quotient in
    // opd: multiplicand / divisor, constant during the run
    logic [WIDTH-1:0] acc, q, opd, cnt;
    logic             div_q;

    logic [WIDTH:0]   sum, shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] acc_nxt, q_nxt;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, opd} : '0);
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, opd};
        // Compare rather than look at a borrow bit: shifted can exceed 2^WIDTH.
        ge      = (shifted >= {1'b0, opd});
        if (div_q) begin
            acc_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end
    end

    // The final iteration and the HI/LO write share one edge, so the parent
    // consumes the next-state values directly.
    assign res_hi = acc_nxt;
    assign res_lo = q_nxt;
    assign last   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            opd   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            q     <= is_div ? opd_a : opd_b;
            opd   <= is_div ? opd_b : opd_a;
            cnt   <= WIDTH'(WIDTH - 1);
            div_q <= is_div;
        end else if (step) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO registers with MTHI/MTLO writes and an
// iterative MULT/MULTU/DIV/DIVU engine (WIDTH cycles busy, result on edge
// k+WIDTH after acceptance at edge k).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op, a, b issue an operation (sampled only when idle)
//   we_hi, we_lo    MTHI / MTLO enables, wdata is the write value
//   rd_hi, rd_lo    current HI / LO
//   busy            operation in flight
//   done            one-cycle pulse when new HI/LO become visible
import hilo_pkg::*;

module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rd_hi,
    output logic [WIDTH-1:0] rd_lo,
    output logic             busy,
    output logic             done
);

    state_t state, state_nxt;
    logic   load, finish, mt_ok;

    logic             it_last;
    logic [WIDTH-1:0] res_hi, res_lo;

    // Operand preparation
    logic             op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        // |most-negative| wraps to itself, which is the right unsigned magnitude.
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
    end

    // Per-operation flags held for the fix-up at the end
    logic             div_q, neg_lo_q, neg_hi_q, dz_q;
    logic [WIDTH-1:0] a_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
        end else if (load) begin
            div_q    <= op_div;
            neg_lo_q <= a_neg ^ b_neg;   // product sign, or quotient sign
            neg_hi_q <= a_neg;           // remainder follows the dividend
            dz_q     <= (b == '0);
            a_q      <= a;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (state == S_RUN),
        .is_div (op_div),
        .opd_a  (mag_a),
        .opd_b  (mag_b),
        .last   (it_last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Control FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Control FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)   state_nxt = S_RUN;
            S_RUN:   if (it_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control FSM: outputs
    always_comb begin
        busy   = (state == S_RUN);
        load   = (state == S_IDLE) && start;
        finish = (state == S_RUN) && it_last;
        mt_ok  = (state == S_IDLE) && !start;
    end

    // Sign fix-up and divide-by-zero override
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod = {res_hi, res_lo};
        if (neg_lo_q) prod = -prod;
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (dz_q) begin
                fin_hi = a_q;
                fin_lo = '1;
            end else begin
                fin_hi = neg_hi_q ? -res_hi : res_hi;
                fin_lo = neg_lo_q ? -res_lo : res_lo;
            end
        end
    end

    // HI/LO ownership
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hi <= '0;
            rd_lo <= '0;
            done  <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                rd_hi <= fin_hi;
                rd_lo <= fin_lo;
            end else if (mt_ok) begin
                if (we_hi) rd_hi <= wdata;
                if (we_lo) rd_lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv (WIDTH=32). Expected HI/LO and the
// expected done cycle are queued on issue; a monitor pops them on done.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, we_hi, we_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata, rd_hi, rd_lo;
    logic         busy, done;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: cyc=%0d hi=%h lo=%h, required no done", cyc, rd_hi, rd_lo);
            end else begin
                mon_e = sb.pop_front();
                if (rd_hi !== mon_e.hi || rd_lo !== mon_e.lo || cyc !== mon_e.cyc || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL result: hi=%h lo=%h cyc=%0d busy=%b, required hi=%h lo=%h cyc=%0d busy=0",
                             rd_hi, rd_lo, cyc, busy, mon_e.hi, mon_e.lo, mon_e.cyc);
                end
            end
        end
    end

    // Drive one start; caller positions between edges. Returns 1ns after the
    // accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic push, input logic [W-1:0] eh, input logic [W-1:0] el);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) sb.push_back('{eh, el, cyc + W});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rd_hi !== '0 || rd_lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required 0/0/0/0", rd_hi, rd_lo, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_mt;
        @(posedge clk); #1;
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
        n_cmp++;
        if (rd_hi !== 32'hCAFE_F00D || rd_lo !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL mt_both: hi=%h lo=%h, required cafef00d/cafef00d", rd_hi, rd_lo);
        end
        we_lo = 1'b1; wdata = 32'h0000_0077;
        @(posedge clk); #1;
        we_lo = 1'b0;
        n_cmp++;
        if (rd_hi !== 32'hCAFE_F00D || rd_lo !== 32'h0000_0077) begin
            n_err++;
            $display("FAIL mt_lo_only: hi=%h lo=%h, required cafef00d/00000077", rd_hi, rd_lo);
        end
    endtask

    task automatic test_mult;
        @(posedge clk); #1;
        issue(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_drain("mult");
        @(posedge clk); #1;
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        wait_drain("mult_mn");
        @(posedge clk); #1;
        issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_drain("mult_neg");
    endtask

    task automatic test_multu;
        @(posedge clk); #1;
        issue(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_drain("multu");
        @(posedge clk); #1;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_drain("multu_max");
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        repeat (W) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_cycle: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        wait_drain("b2b");
        @(posedge clk); #1;
        issue(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        wait_drain("div_negdivisor");
    endtask

    task automatic test_div_zero;
        int nbusy;
        @(posedge clk); #1;
        issue(2'd3, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
        nbusy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        n_cmp++;
        if (nbusy != W) begin
            n_err++;
            $display("FAIL divzero_busy_cycles: %0d, required %0d", nbusy, W);
        end
        wait_drain("divzero");
        @(posedge clk); #1;
        issue(2'd2, 32'h8000_0003, 32'h0000_0000, 1'b1, 32'h8000_0003, 32'hFFFF_FFFF);
        wait_drain("div_signed_zero");
    endtask

    task automatic test_dropped;
        @(posedge clk); #1;
        issue(2'd3, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        repeat (2) @(posedge clk);
        #1;
        we_hi = 1'b1; wdata = 32'h0000_1234;
        op = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        we_hi = 1'b0; start = 1'b0;
        wait_drain("dropped");
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rd_hi !== 32'd2 || rd_lo !== 32'd14) begin
            n_err++;
            $display("FAIL dropped_final: hi=%h lo=%h, required 00000002/0000000e", rd_hi, rd_lo);
        end
        @(posedge clk); #1;
        we_lo = 1'b1; wdata = 32'hDEAD_BEEF;
        issue(2'd1, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
        we_lo = 1'b0;
        wait_drain("start_priority");
    endtask

    task automatic test_reset_mid;
        int ndone;
        @(posedge clk); #1;
        we_hi = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b1; wdata = 32'h0000_5555;
        @(posedge clk); #1;
        we_lo = 1'b0;
        n_cmp++;
        if (rd_hi !== 32'h0000_AAAA || rd_lo !== 32'h0000_5555) begin
            n_err++;
            $display("FAIL preload: hi=%h lo=%h, required 0000aaaa/00005555", rd_hi, rd_lo);
        end
        issue(2'd0, 32'd3, 32'd5, 1'b0, '0, '0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (rd_hi !== '0 || rd_lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_state: hi=%h lo=%h busy=%b done=%b, required 0/0/0/0", rd_hi, rd_lo, busy, done);
        end
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_err++;
            $display("FAIL reset_mid_done: %0d pulses, required 0", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult();
        test_multu();
        test_back_to_back();
        test_div_zero();
        test_dropped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
